// File: rtl/salu_pkg.sv
// Shared types and helpers for the salu_bitcnt multi-cycle bit-count unit.
package salu_pkg;

  typedef enum logic [1:0] {
    OP_CLZ = 2'd0,
    OP_CLO = 2'd1,
    OP_CTZ = 2'd2,
    OP_POP = 2'd3
  } salu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } salu_state_e;

  // Widest operand the reversal helper can handle; callers cast the result
  // back down to their own width.
  localparam int REV_MAX_W = 256;
  localparam int REV_IW    = $clog2(REV_MAX_W);

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] v,
                                                   input int w);
    logic [REV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_MAX_W; i++) begin
      if (i < w) r[REV_IW'(i)] = v[REV_IW'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/salu_bitcnt_if.sv
// Request/response bus of the bit-count unit: request handshake, result
// handshake and the busy stall indication.
interface salu_bitcnt_if
  import salu_pkg::*;
#(
  parameter int WIDTH = 32
);
  localparam int RW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  salu_op_e         op;
  logic [WIDTH-1:0] operand;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;
  logic             busy;

  modport master (
    output in_valid, op, operand, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, operand, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/salu_chunk_cnt.sv
// Combinational counts for one STEP-bit chunk: leading zeros (MSB side),
// all-zero flag and population count.
module salu_chunk_cnt #(
  parameter int STEP = 4
) (
  input  logic [STEP-1:0]              chunk,
  output logic [$clog2(STEP+1)-1:0]    lz,
  output logic [$clog2(STEP+1)-1:0]    pop,
  output logic                         all_zero
);
  localparam int CW = $clog2(STEP + 1);

  // Walk from LSB upward so the highest set bit decides the leading-zero count.
  always_comb begin
    lz  = CW'(STEP);
    pop = '0;
    for (int i = 0; i < STEP; i++) begin
      if (chunk[i]) lz = CW'(STEP - 1 - i);
      pop = pop + CW'(chunk[i]);
    end
  end

  assign all_zero = ~|chunk;

endmodule

// File: rtl/salu_bitcnt.sv
// Multi-cycle CLZ/CLO/CTZ/POPCNT unit scanning STEP bits per cycle, MSB chunk
// first. CLO and CTZ are mapped onto a leading-zero scan by normalising the
// operand at accept time (invert / bit-reverse).
// Optional macro SALU_FASTPATH_EN: all-zero normalised operands (and all-ones
// for POP) finish straight from the accept edge without entering RUN.
module salu_bitcnt
  import salu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  salu_bitcnt_if.slave bus
);
  localparam int NCHUNK = WIDTH / STEP;
  localparam int RW     = $clog2(WIDTH + 1);
  localparam int CW     = $clog2(STEP + 1);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  salu_state_e      state_q, state_d;
  salu_op_e         op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] norm;
  logic [RW-1:0]    count_q;
  logic [RW-1:0]    count_nxt;
  logic [RW-1:0]    result_q;
  logic [KW-1:0]    k_q;
  logic [CW-1:0]    lz_c;
  logic [CW-1:0]    pop_c;
  logic             zero_c;
  logic             accept;
  logic             scan_last;

  assign accept = bus.in_valid & bus.in_ready;

  // Map every leading/trailing mode onto a leading-zero scan.
  always_comb begin
    norm = bus.operand;
    case (bus.op)
      OP_CLO:  norm = ~bus.operand;
      OP_CTZ:  norm = WIDTH'(bit_rev(REV_MAX_W'(bus.operand), WIDTH));
      default: norm = bus.operand;
    endcase
  end

`ifdef SALU_FASTPATH_EN
  logic          fast_hit;
  logic [RW-1:0] fast_res;
  assign fast_hit = (norm == '0) | ((bus.op == OP_POP) & (&norm));
  assign fast_res = ((bus.op == OP_POP) & (norm == '0)) ? '0 : RW'(WIDTH);
`endif

  // The operand shifts left each RUN cycle, so the current chunk is always on top.
  salu_chunk_cnt #(.STEP(STEP)) u_chunk (
    .chunk    (opnd_q[WIDTH-1 -: STEP]),
    .lz       (lz_c),
    .pop      (pop_c),
    .all_zero (zero_c)
  );

  assign count_nxt = count_q + ((op_q == OP_POP) ? RW'(pop_c) : RW'(lz_c));
  assign scan_last = (k_q == KW'(NCHUNK - 1)) | ((op_q != OP_POP) & ~zero_c);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; reset and flush both abort to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SALU_FASTPATH_EN
          state_d = fast_hit ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (scan_last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset | flush) state_d = IDLE;
  end

  // Datapath: latch normalised operand at accept, accumulate one chunk per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else if (flush) begin
      count_q <= '0;
      k_q     <= '0;
    end else if (accept) begin
      opnd_q  <= norm;
      op_q    <= bus.op;
      count_q <= '0;
      k_q     <= '0;
`ifdef SALU_FASTPATH_EN
      if (fast_hit) result_q <= fast_res;
`endif
    end else if (state_q == RUN) begin
      count_q <= count_nxt;
      k_q     <= k_q + 1'b1;
      opnd_q  <= opnd_q << STEP;
      if (scan_last) result_q <= count_nxt;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~flush;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_salu_bitcnt.sv
// Scoreboard bench for salu_bitcnt (WIDTH=32, STEP=4): the driver pushes the
// expected count and latency per accepted request, a monitor pops and compares
// whenever the unit presents a result.
module tb_salu_bitcnt;
  import salu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic ready_val;
  logic rnd_mode;
  logic rnd_bit = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  typedef struct {
    int res;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];

  salu_bitcnt_if #(.WIDTH(32)) bus ();

  salu_bitcnt #(.WIDTH(32), .STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.out_ready = rnd_mode ? rnd_bit : ready_val;

  initial forever begin
    @(negedge clk);
    rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: count directly from the definition of each operation.
  function automatic int ref_count(input int op, input logic [31:0] x);
    int n;
    n = 0;
    case (op)
      0: for (int i = 31; i >= 0; i--) begin if (x[i]) break; n++; end
      1: for (int i = 31; i >= 0; i--) begin if (!x[i]) break; n++; end
      2: for (int i = 0; i < 32; i++) begin if (x[i]) break; n++; end
      default: n = $countones(x);
    endcase
    return n;
  endfunction

  // Chunks examined: up to and including the first one holding the deciding bit.
  function automatic int ref_lat(input int op, input logic [31:0] x, input int res);
`ifdef SALU_FASTPATH_EN
    if (op != 3 && res == 32) return 0;
    if (op == 3 && (x == 32'h0 || x == 32'hFFFF_FFFF)) return 0;
`endif
    if (op == 3 || res == 32) return 8;
    return res / 4 + 1;
  endfunction

  task automatic issue(input salu_op_e op, input logic [31:0] x);
    int t;
    exp_t e;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      chk("issue_timeout", 1, 0);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.operand  = x;
    e.res = ref_count(int'(op), x);
    e.lat = ref_lat(int'(op), x, e.res);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.busy) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("done_timeout", 1, 0);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("valid_timeout", 1, 0);
  endtask

  // Monitor: first cycle of each result pops the scoreboard; stall cycles must hold it.
  initial begin
    exp_t e;
    int   held;
    bit   active;
    held   = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset || flush) begin
        active = 1'b0;
      end else if (bus.out_valid) begin
        if (!active) begin
          if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_result: got out_valid=1 result=%0d, required none pending",
                     bus.result);
          end else begin
            e = q.pop_front();
            chk("result", int'(bus.result), e.res);
            chk("latency", cyc - e.acc, e.lat);
          end
          held   = int'(bus.result);
          active = 1'b1;
        end else begin
          chk("result_hold", int'(bus.result), held);
        end
        if (bus.out_ready) active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ov_seen;
    reset        = 1'b1;
    flush        = 1'b0;
    ready_val    = 1'b1;
    rnd_mode     = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = OP_CLZ;
    bus.operand  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);

    issue(OP_CLZ, 32'h0001_0000); wait_done();
    issue(OP_CLO, 32'hFFFF_FFF0); wait_done();
    issue(OP_CTZ, 32'h0000_0100); wait_done();
    issue(OP_POP, 32'hF0F0_1234); wait_done();
    issue(OP_CLZ, 32'h0000_0000); wait_done();

    // Backpressure, then a back-to-back request right after the handshake.
    ready_val = 1'b0;
    issue(OP_CLZ, 32'h0001_0000);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_result", int'(bus.result), 15);
      chk("bp_in_ready", int'(bus.in_ready), 0);
      chk("bp_busy", int'(bus.busy), 1);
      @(negedge clk);
    end
    ready_val = 1'b1;
    @(negedge clk);
    #1;
    chk("b2b_in_ready", int'(bus.in_ready), 1);
    issue(OP_CTZ, 32'h0000_0100);
    wait_done();

    // Flush during RUN discards the operation.
    issue(OP_CLZ, 32'h0000_0001);
    @(negedge clk);
    flush = 1'b1;
    q.delete();
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_in_ready", int'(bus.in_ready), 1);
    chk("flush_busy", int'(bus.busy), 0);
    ov_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
    end
    chk("flush_no_out", int'(ov_seen), 0);

    // Flush coincident with a request blocks acceptance.
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = OP_CLZ;
    bus.operand  = 32'h5;
    #1;
    chk("flush_blocks_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("flush_no_accept", int'(bus.busy), 0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    issue(OP_CLO, 32'h8000_0000); wait_done();

    // Reset while a result waits in DONE.
    ready_val = 1'b0;
    issue(OP_POP, 32'h0000_00F0);
    wait_valid();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstdone_out_valid", int'(bus.out_valid), 0);
    chk("rstdone_in_ready", int'(bus.in_ready), 1);
    chk("rstdone_busy", int'(bus.busy), 0);
    chk("rstdone_result", int'(bus.result), 0);
    ready_val = 1'b1;
    issue(OP_POP, 32'hFFFF_FFFF); wait_done();

    // Randomised operations with random consumer backpressure.
    rnd_mode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      salu_op_e    o;
      logic [31:0] x;
      o = salu_op_e'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       x = $urandom;
        1:       x = 32'h1 << $urandom_range(0, 31);
        2:       x = ~(32'h1 << $urandom_range(0, 31));
        3:       x = $urandom >> $urandom_range(0, 31);
        4:       x = 32'h0;
        default: x = 32'hFFFF_FFFF;
      endcase
      issue(o, x);
    end
    wait_done();
    rnd_mode = 1'b0;
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/salu_bitcnt.md
Name: salu_bitcnt

Overview:
- Parametrised multi-cycle bit-count unit; successor to the single-width iterative CLO/CLZ special ALU in the execute stage.
- Supports CLZ, CLO, CTZ and POPCNT on a WIDTH-bit operand.
- Scans STEP bits per cycle, MSB chunk first, with early termination for the leading/trailing modes.
- Uses valid/ready handshakes on both input and output, plus a pipeline flush.

Parameters:
- WIDTH, 32, operand width; power of two, ≥8.
- STEP, 4, bits examined per cycle; power of two, divides WIDTH.
- NCHUNK, WIDTH/STEP, derived (localparam).
- RW, $clog2(WIDTH+1), derived result width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous abort of any operation in flight
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request
- op  in  2  operation code from package: OP_CLZ=0, OP_CLO=1, OP_CTZ=2, OP_POP=3
- operand  in  WIDTH  source value
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- result  out  RW  count, zero-extended by the consumer
- busy  out  1  high in RUN or DONE (stall source for the pipeline)

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0.
- FSM has three states:
  - IDLE → RUN on in_valid&in_ready (the accept edge, edge 0).
  - RUN → DONE when the scan terminates.
  - DONE → IDLE on out_valid&out_ready.
- in_ready = (state==IDLE) & !flush. There is no acceptance in RUN or DONE.
- Operand normalisation at accept, latched into an internal register:
  - CLZ and POP: unchanged.
  - CLO: bitwise inverted.
  - CTZ: bit-reversed.
  - op is latched alongside the operand.
- RUN, per edge: take chunk index k (0 = bits WIDTH-1..WIDTH-STEP).
  - Leading modes (CLZ/CLO/CTZ): if the chunk is all zero, count += STEP and k++. Otherwise count += leading-zero count of the chunk and the scan terminates.
  - POP: count += popcount(chunk) and k++.
  - Termination also occurs after chunk NCHUNK-1 has been processed.
- Latency: out_valid is high after edge N, where N = number of chunks examined.
  - Leading modes: N = (index of first nonzero chunk)+1, or NCHUNK if the operand is all zero.
  - POP: N = NCHUNK always.
- Count arithmetic is RW bits wide and cannot overflow; the maximum value is WIDTH.
- DONE:
  - out_valid=1; result is held stable until out_ready.
  - Handshake completes in the same cycle out_ready is sampled high; the unit returns to IDLE, with in_ready high the following cycle.
- flush or reset in any state:
  - next state is IDLE; out_valid=0; count and k cleared; a pending result is discarded.
  - flush takes priority over in_valid in the same cycle; no accept occurs.
- result retains its last value after a handshake. The consumer qualifies it with out_valid only.

Optional Feature:
- Macro SALU_FASTPATH_EN.
- Defined: at accept, if the normalised operand is all zero, the unit goes directly to DONE with result = WIDTH (leading modes) or 0 (POP). In POP mode an all-ones operand yields WIDTH. out_valid is high after edge 0 and RUN is skipped.
- Undefined: every operation passes through RUN with the latency given above.

Decomposition:
- Package salu_pkg:
  - salu_op_e (OP_CLZ/OP_CLO/OP_CTZ/OP_POP);
  - salu_state_e (IDLE/RUN/DONE);
  - bit-reverse function.
- Sub-module salu_chunk_cnt #(STEP): combinational, outputs lz (leading zeros of the STEP-bit chunk), all_zero and pop for one chunk. It is instantiated once in the datapath.

Test Plan (WIDTH=32, STEP=4, macro off unless stated):
- CLZ 0x0001_0000 → result 15, out_valid after edge 4.
- CLO 0xFFFF_FFF0 → result 28, after edge 8. CTZ 0x0000_0100 → result 8, after edge 3.
- POP 0xF0F0_1234 → result 13, after edge 8. CLZ 0x0000_0000 → result 32, after edge 8. With SALU_FASTPATH_EN the zero-operand CLZ completes after edge 0.
- Backpressure: out_ready held low 5 cycles after out_valid → result stable, in_ready=0 and busy=1 throughout. Back-to-back request accepted the cycle after the handshake.
- flush asserted during RUN of CLZ 0x0000_0001 → IDLE next cycle, out_valid never rises. flush coincident with in_valid in IDLE → not accepted. A following CLO 0x8000_0000 returns 1.
- reset asserted in DONE with out_ready low → out_valid=0, in_ready=1 next cycle. A subsequent POP 0xFFFF_FFFF returns 32.
